wb_regfile: RTL and testbench

- Write-back end of the MEM/WB interface: consumes the WB-side signals (regWrite, memToReg, write_reg, alu_out, read_data, pc_plus, sign_ext_low_bits).
- Selects the write-back value and commits it into an 8 x 16-bit register file.
- Provides two decode-stage read ports with same-cycle write-to-read bypass.
- Exports the write-back value for forwarding and keeps a retired-instruction counter.

---
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back source, commits it into an 8 x 16-bit
// register file, serves two bypassed decode read ports and counts retired instructions.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              wb_regWrite,
    input  logic [1:0]        wb_memToReg,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_alu_out,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_pc_plus,
    input  logic [DATA_W-1:0] wb_sign_ext_low_bits,
    input  logic [REG_AW-1:0] rd_reg1,
    input  logic [REG_AW-1:0] rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              wb_fwd_valid,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int NUM_REGS = 1 << REG_AW;

    // Handshake: wb_valid marks a real instruction each cycle (no ready, WB never
    // stalls); the write commits on the edge ending any cycle where we is high.
    logic                   we;
    logic [DATA_W-1:0]      wb_mux;
    logic [DATA_W-1:0]      regs [NUM_REGS];
    logic [CNT_W-1:0]       count_q;

    always_comb begin
        case (wb_memToReg)
            2'b00:   wb_mux = wb_alu_out;
            2'b01:   wb_mux = wb_read_data;
            2'b10:   wb_mux = wb_pc_plus;
            default: wb_mux = wb_sign_ext_low_bits;
        endcase
    end

    assign we            = !rst && wb_valid && wb_regWrite;
    assign wb_write_data = wb_mux;
    assign wb_fwd_valid  = we;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wb_write_reg] <= wb_mux;
        end
    end

    // Bypass lets decode see the value committing this cycle without waiting an edge.
    always_comb begin
        rd_data1 = regs[rd_reg1];
        rd_data2 = regs[rd_reg2];
        if (we && (rd_reg1 == wb_write_reg)) begin
            rd_data1 = wb_mux;
        end
        if (we && (rd_reg2 == wb_write_reg)) begin
            rd_data2 = wb_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wb_valid) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign retire_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised and directed stimulus against a register-array reference model;
// expected outputs are queued per cycle and checked by an independent monitor.
`timescale 1ns/1ps
module tb_wb_regfile;

  localparam int W = 65;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_regWrite;
  logic [1:0]  wb_memToReg;
  logic [2:0]  wb_write_reg;
  logic [15:0] wb_alu_out;
  logic [15:0] wb_read_data;
  logic [15:0] wb_pc_plus;
  logic [15:0] wb_sign_ext_low_bits;
  logic [2:0]  rd_reg1;
  logic [2:0]  rd_reg2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic [15:0] wb_write_data;
  logic        wb_fwd_valid;
  logic [15:0] retire_count;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_memToReg(wb_memToReg), .wb_write_reg(wb_write_reg),
    .wb_alu_out(wb_alu_out), .wb_read_data(wb_read_data),
    .wb_pc_plus(wb_pc_plus), .wb_sign_ext_low_bits(wb_sign_ext_low_bits),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_write_data(wb_write_data), .wb_fwd_valid(wb_fwd_valid),
    .retire_count(retire_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_regWrite = 1'b0; wb_memToReg = 2'b00;
    wb_write_reg = '0; wb_alu_out = '0; wb_read_data = '0; wb_pc_plus = '0;
    wb_sign_ext_low_bits = '0; rd_reg1 = '0; rd_reg2 = '0;
  end

  // scoreboard state and reference model
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [15:0]  m_regs[8];
  logic [15:0]  m_cnt;
  bit           model_ok = 1'b0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endfunction

  // driver: one call = one clock cycle of WB-stage inputs
  task automatic drive(input logic r, input logic v, input logic rw, input logic [1:0] s,
                       input logic [2:0] wr, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] p, input logic [15:0] e,
                       input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] src[4];
    logic [15:0] val, x1, x2;
    logic        commit;
    @(posedge clk);
    #1;
    rst = r; wb_valid = v; wb_regWrite = rw; wb_memToReg = s; wb_write_reg = wr;
    wb_alu_out = a; wb_read_data = d; wb_pc_plus = p; wb_sign_ext_low_bits = e;
    rd_reg1 = r1; rd_reg2 = r2;
    src[0] = a; src[1] = d; src[2] = p; src[3] = e;
    val    = src[s];
    commit = !r && v && rw;
    if (model_ok) begin
      x1 = (commit && r1 == wr) ? val : m_regs[r1];
      x2 = (commit && r2 == wr) ? val : m_regs[r2];
      exp_q.push_back({x1, x2, val, m_cnt, commit});
    end
    if (r) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_cnt    = 16'h0000;
      model_ok = 1'b1;
    end else begin
      if (commit) m_regs[wr] = val;
      if (v) m_cnt = m_cnt + 16'h0001;
    end
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, r1, r2);
  endtask

  task automatic write(input logic [1:0] s, input logic [2:0] wr, input logic [15:0] v,
                       input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] a, d, p, e;
    a = 16'($urandom); d = 16'($urandom); p = 16'($urandom); e = 16'($urandom);
    case (s)
      2'b00:   a = v;
      2'b01:   d = v;
      2'b10:   p = v;
      default: e = v;
    endcase
    drive(1'b0, 1'b1, 1'b1, s, wr, a, d, p, e, r1, r2);
  endtask

  task automatic rand_cycle(input logic force_valid);
    drive(($urandom_range(0, 39) == 0), force_valid | 1'($urandom), 1'($urandom),
          2'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), 3'($urandom), 3'($urandom));
  endtask

  // monitor: compares every cycle the scoreboard has an expectation for
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data1", rd_data1, e[64:49]);
        chk("rd_data2", rd_data2, e[48:33]);
        chk("wb_write_data", wb_write_data, e[32:17]);
        chk("retire_count", retire_count, e[16:1]);
        chk("wb_fwd_valid", {15'd0, wb_fwd_valid}, {15'd0, e[0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset and read every address on both ports
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i), 3'(7 - i));
      @(negedge clk);
      chk("reset_rd1", rd_data1, 16'h0000);
      chk("reset_rd2", rd_data2, 16'h0000);
      chk("reset_cnt", retire_count, 16'h0000);
    end

    // one write per source select, read back next cycle
    write(2'b00, 3'd3, 16'h1234, 3'd0, 3'd0);
    idle(3'd3, 3'd0); @(negedge clk); chk("src00_r3", rd_data1, 16'h1234);
    write(2'b01, 3'd4, 16'hBEEF, 3'd0, 3'd0);
    idle(3'd4, 3'd3); @(negedge clk); chk("src01_r4", rd_data1, 16'hBEEF);
    write(2'b10, 3'd5, 16'h0102, 3'd0, 3'd0);
    idle(3'd5, 3'd4); @(negedge clk); chk("src10_r5", rd_data1, 16'h0102);
    write(2'b11, 3'd6, 16'hFFF9, 3'd0, 3'd0);
    idle(3'd6, 3'd5); @(negedge clk); chk("src11_r6", rd_data1, 16'hFFF9);

    // same-cycle bypass on both ports
    write(2'b00, 3'd2, 16'h0001, 3'd0, 3'd0);
    write(2'b01, 3'd2, 16'hA5A5, 3'd2, 3'd2);
    @(negedge clk);
    chk("bypass_rd1", rd_data1, 16'hA5A5);
    chk("bypass_rd2", rd_data2, 16'hA5A5);
    chk("bypass_fwd", {15'd0, wb_fwd_valid}, 16'h0001);
    idle(3'd2, 3'd2); @(negedge clk); chk("bypass_stored", rd_data2, 16'hA5A5);

    // no-write cases on R1
    write(2'b11, 3'd1, 16'h0007, 3'd0, 3'd0);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 16'h9999, 16'h0, 16'h0, 16'h0, 3'd1, 3'd1);
    @(negedge clk); chk("nowrite_rw0", rd_data1, 16'h0007);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 3'd1, 16'h8888, 16'h0, 16'h0, 16'h0, 3'd1, 3'd1);
    @(negedge clk); chk("nowrite_v0", rd_data2, 16'h0007);
    chk("nowrite_fwd", {15'd0, wb_fwd_valid}, 16'h0000);
    idle(3'd1, 3'd1); @(negedge clk); chk("nowrite_held", rd_data1, 16'h0007);

    // reset colliding with a write of R7
    write(2'b00, 3'd7, 16'h1111, 3'd0, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 3'd7, 16'h5555, 16'h0, 16'h0, 16'h0, 3'd7, 3'd7);
    @(negedge clk);
    chk("rst_cycle_old", rd_data1, 16'h1111);
    chk("rst_cycle_nofwd", {15'd0, wb_fwd_valid}, 16'h0000);
    idle(3'd7, 3'd7); @(negedge clk);
    chk("rst_r7_zero", rd_data1, 16'h0000);
    chk("rst_cnt_zero", retire_count, 16'h0000);

    // reset in the middle of a write burst
    write(2'b00, 3'd1, 16'h0101, 3'd0, 3'd0);
    write(2'b00, 3'd2, 16'h0202, 3'd1, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 16'h0303, 16'h0, 16'h0, 16'h0, 3'd3, 3'd2);
    write(2'b00, 3'd4, 16'h0404, 3'd3, 3'd4);
    idle(3'd4, 3'd3); @(negedge clk);
    chk("burst_resume", rd_data1, 16'h0404);
    chk("burst_dropped", rd_data2, 16'h0000);

    // randomised traffic
    for (int i = 0; i < 400; i++) rand_cycle(1'b0);

    // retire counter wrap
    drive(1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 65535; i++) begin
      drive(1'b0, 1'b1, 1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
    @(negedge clk); chk("cnt_ffff", retire_count, 16'hFFFF);
    idle(3'd0, 3'd0); @(negedge clk); chk("cnt_wrap", retire_count, 16'h0000);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
